// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle control unit: sequencer
// states, instruction-class codes and the HALT opcode pattern.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [2:0] CLS_ALU   = 3'd0;
  localparam logic [2:0] CLS_IMM   = 3'd1;
  localparam logic [2:0] CLS_L     = 3'd2;
  localparam logic [2:0] CLS_S     = 3'd3;
  localparam logic [2:0] CLS_BRA   = 3'd4;
  localparam logic [2:0] CLS_TR    = 3'd5;
  localparam logic [2:0] CLS_STACK = 3'd6;
  localparam logic [2:0] CLS_MOV   = 3'd7;

  typedef struct packed {
    logic alu;
    logic imm;
    logic l;
    logic s;
    logic bra;
    logic tr;
    logic stack;
    logic mov;
  } cls_flags_t;

  localparam int OPW_MAX = 32;

  // HALT is the all-ones opcode for whatever opcode width is in use.
  function automatic logic [OPW_MAX-1:0] halt_op(input int opw);
    logic [OPW_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < opw; i++) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational class decode: maps the opcode class field to one-hot flags
// and detects HALT; the sequencer registers these results.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output cu_pkg::cls_flags_t flags,
  output logic           halt
);

  localparam logic [OPW-1:0] HALT_OP = OPW'(halt_op(OPW));

  logic [2:0] cls;
  assign cls = opcode[OPW-1 -: 3];

  always_comb begin
    flags = '0;
    halt  = (opcode == HALT_OP);
    // HALT lives inside the MOV class encoding but must raise no flag.
    if (!halt) begin
      case (cls)
        CLS_ALU:   flags.alu   = 1'b1;
        CLS_IMM:   flags.imm   = 1'b1;
        CLS_L:     flags.l     = 1'b1;
        CLS_S:     flags.s     = 1'b1;
        CLS_BRA:   flags.bra   = 1'b1;
        CLS_TR:    flags.tr    = 1'b1;
        CLS_STACK: flags.stack = 1'b1;
        CLS_MOV:   flags.mov   = 1'b1;
        default:   flags       = '0;
      endcase
    end
  end

endmodule

// File: rtl/cu_seq.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/[MEM]/WB and drives PC, register-file and memory strobes.
module cu_seq
  import cu_pkg::*;
#(
  parameter int OPW          = 6,
  parameter int MEM_WAIT_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  input  logic [OPW-1:0] opcode,
  input  logic           cond,
  input  logic           mem_ready,
  output logic           ALU,
  output logic           IMM,
  output logic           L,
  output logic           S,
  output logic           BRA,
  output logic           TR,
  output logic           STACK,
  output logic           MOV,
  output logic [OPW-4:0] alu_op,
  output logic           busy,
  output logic           ir_load,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           mem_req,
  output logic           mem_we,
  output logic           rf_we,
  output logic           done,
  output logic           err,
  output logic           halted
);

  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MEM_WAIT_MAX);

  state_t         state_q, state_d;
  logic [OPW-1:0] ir_q;
  cls_flags_t     flags_q;
  logic [OPW-4:0] alu_op_q;
  logic           err_q, err_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [WW-1:0]  wait_inc;

  cls_flags_t dec_flags;
  logic       dec_halt;

  cu_decode #(.OPW(OPW)) u_decode (
    .opcode (ir_q),
    .flags  (dec_flags),
    .halt   (dec_halt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      flags_q  <= '0;
      alu_op_q <= '0;
      err_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      if (state_q == ST_FETCH) ir_q <= opcode;
      if (state_q == ST_DECODE) begin
        flags_q  <= dec_flags;
        alu_op_q <= ir_q[OPW-4:0];
      end
    end
  end

  assign wait_inc = wait_q + WW'(1);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d = ST_FETCH;
          err_d   = 1'b0;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = dec_halt ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (flags_q.l || flags_q.s || flags_q.stack) begin
          state_d = ST_MEM;
          wait_d  = '0;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // A ready in the last counted cycle wins over the timeout.
        if (mem_ready) begin
          state_d = ST_WB;
        end else if (wait_inc == WAIT_LIM) begin
          wait_d  = WAIT_LIM;
          state_d = ST_WB;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_WB: begin
        if (instr_valid) begin
          state_d = ST_FETCH;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ALU    = flags_q.alu;
  assign IMM    = flags_q.imm;
  assign L      = flags_q.l;
  assign S      = flags_q.s;
  assign BRA    = flags_q.bra;
  assign TR     = flags_q.tr;
  assign STACK  = flags_q.stack;
  assign MOV    = flags_q.mov;
  assign alu_op = alu_op_q;

  // STACK sub-op bit0: 0 = push (memory write), 1 = pop (register write).
  assign busy    = (state_q != ST_IDLE);
  assign ir_load = (state_q == ST_FETCH);
  assign pc_inc  = (state_q == ST_FETCH);
  assign pc_load = (state_q == ST_EXEC) && flags_q.bra && cond;
  assign mem_req = (state_q == ST_MEM);
  assign mem_we  = (state_q == ST_MEM) && (flags_q.s || (flags_q.stack && !alu_op_q[0]));
  assign done    = (state_q == ST_WB);
  assign rf_we   = (state_q == ST_WB) && !err_q &&
                   (flags_q.alu || flags_q.imm || flags_q.tr || flags_q.mov ||
                    flags_q.l || (flags_q.stack && alu_op_q[0]));
  assign err     = err_q;
  assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_cu_seq.sv
// Bench for cu_seq: directed scenarios plus a random instruction stream, each
// cycle compared against an instruction-level model of expected strobes.
module tb_cu_seq;

  localparam int OPW  = 6;
  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instr_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic       cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ALU, IMM, L, S, BRA, TR, STACK, MOV;
  logic [2:0] alu_op;
  logic       busy, ir_load, pc_inc, pc_load, mem_req, mem_we, rf_we, done, err, halted;

  cu_seq #(.OPW(OPW), .MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .cond(cond), .mem_ready(mem_ready),
    .ALU(ALU), .IMM(IMM), .L(L), .S(S), .BRA(BRA), .TR(TR), .STACK(STACK), .MOV(MOV),
    .alu_op(alu_op), .busy(busy), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we),
    .done(done), .err(err), .halted(halted)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: what the class/sub-op/err registers should currently show.
  logic [7:0] m_flags = '0;
  logic [2:0] m_op = '0;
  logic       m_err = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ALU,IMM,L,S,BRA,TR,STACK,MOV}: class c lights bit 7-c; HALT lights none.
  function automatic logic [7:0] flags_of(input logic [5:0] op);
    if (op == 6'h3F) return 8'h00;
    return 8'h80 >> op[5:3];
  endfunction

  // Strobe vector order: busy ir_load pc_inc pc_load mem_req mem_we rf_we done err halted
  task automatic check_all(input string phase, input logic [9:0] exp_strb);
    check({phase, "/strobes"},
          {6'b0, busy, ir_load, pc_inc, pc_load, mem_req, mem_we, rf_we, done, err, halted},
          {6'b0, exp_strb});
    check({phase, "/flags"}, {8'b0, ALU, IMM, L, S, BRA, TR, STACK, MOV}, {8'b0, m_flags});
    check({phase, "/alu_op"}, {13'b0, alu_op}, {13'b0, m_op});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
      opcode      = 6'($urandom);
      cond        = 1'($urandom);
      mem_ready   = 1'($urandom);
      @(negedge clk);
      check_all("idle", {8'b0, m_err, 1'b0});
    end
  endtask

  // Call only while the DUT sits in IDLE, just after a negedge.
  task automatic start(input logic [5:0] op);
    instr_valid = 1'b1;
    opcode      = op;
  endtask

  // Runs one instruction from FETCH through WB (or into HALT). rdy_at is the
  // 0-based MEM cycle in which mem_ready rises; >= MAXW means never.
  task automatic run_instr(input logic [5:0] op, input logic c, input int rdy_at,
                           input logic nv, input logic [5:0] nop);
    int  cls, nm, total;
    bit  is_halt, is_mem, pop, tmo, wr_rf, wr_mem, last;
    cls     = int'(op[5:3]);
    is_halt = (op == 6'h3F);
    is_mem  = !is_halt && (cls == 2 || cls == 3 || cls == 6);
    pop     = op[0];
    tmo     = is_mem && (rdy_at >= MAXW);
    nm      = !is_mem ? 0 : (tmo ? MAXW : rdy_at + 1);
    wr_rf   = !is_halt && (cls == 0 || cls == 1 || cls == 2 || cls == 5 || cls == 7 ||
                           (cls == 6 && pop));
    wr_mem  = (cls == 3) || (cls == 6 && !pop);
    total   = is_halt ? 2 : 4 + nm;
    for (int k = 0; k < total; k++) begin
      @(posedge clk); #1;
      last        = (k == total - 1) && !is_halt;
      instr_valid = last ? nv : 1'($urandom);
      if (k > 0) opcode = (last && nv) ? nop : 6'($urandom);
      cond        = (k == 2) ? c : 1'($urandom);
      mem_ready   = (k >= 3 && k < 3 + nm) ? ((k - 3) == rdy_at) : 1'($urandom);
      @(negedge clk);
      if (k == 2) begin
        m_flags = flags_of(op);
        m_op    = op[2:0];
      end
      if (k == 0) begin
        m_err = 1'b0;
        check_all("fetch", 10'b1110000000);
      end else if (k == 1) begin
        check_all("decode", 10'b1000000000);
      end else if (k == 2) begin
        check_all("exec", {3'b100, (cls == 4) && c, 6'b0});
      end else if (!last) begin
        check_all("mem", {4'b1000, 1'b1, wr_mem, 4'b0});
      end else begin
        m_err = tmo;
        check_all("wb", {6'b100000, wr_rf && !tmo, 1'b1, tmo, 1'b0});
      end
    end
    if (is_halt) begin
      m_flags = 8'h00;
      m_op    = op[2:0];
    end
  endtask

  task automatic reset_now(input string tag);
    rst     = 1'b0;
    m_flags = '0;
    m_op    = '0;
    m_err   = 1'b0;
    #1;
    check_all(tag, 10'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] cur, nxt;
    logic       nv;

    // Reset held from time zero, then a quiet idle period.
    repeat (2) @(negedge clk);
    check_all("reset0", 10'b0);
    rst = 1'b1;
    idle(3);

    // ALU with cond high: pc_load must stay low.
    start(6'b000101);
    run_instr(6'b000101, 1'b1, 0, 1'b0, 6'b0);
    idle(1);

    // Load, mem_ready on the 3rd MEM cycle.
    start(6'b010000);
    run_instr(6'b010000, 1'b0, 2, 1'b0, 6'b0);
    idle(1);

    // Store with mem_ready held low: timeout, err persists through IDLE.
    start(6'b011000);
    run_instr(6'b011000, 1'b0, 99, 1'b0, 6'b0);
    idle(2);

    // Branch taken then not taken, back to back.
    start(6'b100000);
    run_instr(6'b100000, 1'b1, 0, 1'b1, 6'b100000);
    run_instr(6'b100000, 1'b0, 0, 1'b0, 6'b0);
    idle(1);

    // Stack push (zero wait) then pop with ready in the final counted cycle.
    start(6'b110000);
    run_instr(6'b110000, 1'b0, 0, 1'b1, 6'b110001);
    run_instr(6'b110001, 1'b0, MAXW - 1, 1'b0, 6'b0);
    idle(1);

    // Asynchronous reset mid-cycle while idle with flags populated.
    #2;
    reset_now("rst_idle");
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    // Random instruction stream.
    do cur = 6'($urandom); while (cur == 6'h3F);
    start(cur);
    for (int i = 0; i < 30; i++) begin
      do nxt = 6'($urandom); while (nxt == 6'h3F);
      nv = (i == 29) ? 1'b0 : 1'($urandom);
      run_instr(cur, 1'($urandom), int'($urandom_range(0, 6)), nv, nxt);
      if (!nv) begin
        idle(int'($urandom_range(1, 2)));
        if (i != 29) start(nxt);
      end
      cur = nxt;
    end

    // Reset during the second MEM cycle of a stalled load.
    start(6'b010000);
    repeat (5) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
      mem_ready   = 1'b0;
    end
    @(negedge clk);
    check("rst_mem/mem_req_before", {15'b0, mem_req}, 16'd1);
    #2;
    reset_now("rst_mem");
    repeat (3) begin
      @(negedge clk);
      check_all("rst_mem/held", 10'b0);
    end
    rst = 1'b1;
    idle(2);

    // HALT: stays halted regardless of instr_valid until reset.
    start(6'b111111);
    run_instr(6'b111111, 1'b0, 0, 1'b0, 6'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      instr_valid = (i == 0) ? 1'b1 : 1'($urandom);
      opcode      = 6'($urandom);
      mem_ready   = 1'($urandom);
      @(negedge clk);
      check_all("halt", {1'b1, 7'b0, m_err, 1'b1});
    end
    #2;
    reset_now("rst_halt");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cu_seq.md
# cu_seq

Parametrised multi-cycle control unit that succeeds the single-cycle opcode decoder. It latches an opcode and decodes it into one-hot instruction-class flags. A state machine then sequences each instruction through fetch, decode, execute, optional memory access and writeback. The memory phase uses a request/ready handshake with a bounded wait. The block sits between instruction memory and the datapath, driving register-file, PC and memory strobes.

## Interface
Parameters:
- OPW, 6: opcode width, minimum 4; top 3 bits are the class field, low OPW-3 bits are the sub-op.
- MEM_WAIT_MAX, 8: maximum MEM cycles without mem_ready before timeout, range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- instr_valid  in  1  opcode on `opcode` is valid; sampled in IDLE and WB
- opcode  in  OPW  instruction opcode; captured in FETCH
- cond  in  1  branch condition from datapath; sampled in EXEC
- mem_ready  in  1  memory accepts/completes the current access
- ALU, IMM, L, S, BRA, TR, STACK, MOV  out  1 each  one-hot class flags, registered
- alu_op  out  OPW-3  registered sub-op field
- busy  out  1  high in every state except IDLE
- ir_load  out  1  opcode capture strobe
- pc_inc  out  1  PC increment strobe
- pc_load  out  1  branch-taken strobe
- mem_req  out  1  memory request
- mem_we  out  1  memory write qualifier
- rf_we  out  1  register-file write strobe
- done  out  1  instruction completes this cycle
- err  out  1  memory timeout on the last instruction
- halted  out  1  HALT executed

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Class field decode, from opcode[OPW-1:OPW-3]:
  - 000 ALU, 001 IMM, 010 L, 011 S, 100 BRA, 101 TR, 110 STACK, 111 MOV.
  - All-ones opcode is HALT. No class flag is set for HALT.
- IDLE: if instr_valid, go to FETCH.
- FETCH: ir_load=1, pc_inc=1. The opcode register captures `opcode` at the exiting edge. err clears.
- DECODE: class flags and alu_op are registered at the exiting edge. They hold until the next DECODE.
  - HALT opcode goes to HALT; every other opcode goes to EXEC.
- EXEC:
  - pc_load = BRA & cond.
  - L, S and STACK go to MEM. All other classes go to WB.
- MEM:
  - mem_req=1 for the whole state.
  - mem_we = S | (STACK & alu_op[0]==0). STACK sub-op bit0=0 is push, bit0=1 is pop.
  - mem_ready=1 goes to WB.
  - Otherwise a wait counter increments. Reaching MEM_WAIT_MAX goes to WB with err set.
- WB:
  - done=1.
  - rf_we = (ALU | IMM | TR | MOV | L | STACK-pop) & ~err.
  - If instr_valid, go to FETCH (back-to-back); else go to IDLE.
- HALT: halted=1, busy=1. instr_valid is ignored. The only exit is reset.
- Strobes are Moore outputs of the state and class registers; pc_load additionally depends on cond.

## Timing
- Reset (rst=0) forces IDLE asynchronously. All outputs go to 0, including class flags, alu_op, err, halted and the wait counter.
  - Reset mid-MEM drops mem_req immediately. No WB follows.
- Non-memory instruction: 4 cycles from FETCH to WB inclusive. done is in the 4th cycle.
- Memory instruction: 5 + N cycles, where N is the number of MEM cycles with mem_ready=0.
- mem_ready=1 in the first MEM cycle gives zero wait.
- Timeout: after MEM_WAIT_MAX consecutive MEM cycles with mem_ready low, the next state is WB.
  - err=1 from WB until the next FETCH; rf_we=0.
  - mem_ready arriving in the final counted cycle takes precedence over timeout.
- mem_ready outside MEM is ignored.
- The wait counter clears on MEM entry.
- The counter is ceil(log2(MEM_WAIT_MAX+1)) bits wide and never wraps.
- instr_valid is sampled at the IDLE and WB exit edges only. Back-to-back throughput is one instruction per 4 cycles (non-memory).

## Structure
- Package cu_pkg: state enum, class-code constants (CLS_ALU … CLS_MOV), HALT opcode as all-ones of OPW.
- Sub-module cu_decode: combinational class-field to one-hot flags plus HALT detect. cu_seq registers its outputs.
- Target: about 200 lines of RTL.

## Test plan
- Reset and idle:
  - Stimulus: rst low mid-cycle while idle.
  - Required: every output is 0 immediately; instr_valid=0 keeps IDLE and busy=0.
- ALU instruction:
  - Stimulus: opcode 6'b000101.
  - Required: ALU=1 and alu_op=3'b101 from EXEC; rf_we=1 and done=1 in cycle 4; pc_load never asserts.
- Load with wait:
  - Stimulus: opcode 6'b010000, mem_ready high on the 3rd MEM cycle.
  - Required: mem_req high for 3 cycles; mem_we=0; WB in cycle 7; rf_we=1; err=0.
- Store timeout:
  - Stimulus: MEM_WAIT_MAX=4, opcode 6'b011000, mem_ready held 0.
  - Required: mem_req and mem_we high for 4 cycles; then WB with err=1, rf_we=0 and done=1; err clears at the next FETCH.
- Branch and back-to-back:
  - Stimulus: opcode 6'b100000 with cond=1, then cond=0, with instr_valid held high.
  - Required: pc_load=1 in the first EXEC only; the WB→FETCH transition skips IDLE.
- HALT and reset mid-operation:
  - Stimulus: opcode 6'b111111, then instr_valid pulses; separately, reset asserted during MEM.
  - Required: halted=1 and the state stays HALT until rst, with no class flags set; reset during MEM drops mem_req at once with no done.
